nested_block_checker: RTL and testbench

//  Streaming keyword-balance checker: consumes one ASCII char per valid cycle, splits on delimiters,

---
 rtl/nbc_pkg.sv | 29 ++
 rtl/nbc_char_class.sv | 22 ++
 rtl/nested_block_checker.sv | 105 ++++++++++
 tb/tb_nested_block_checker.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/nbc_pkg.sv
// Shared definitions for the nested begin/end keyword checker.
// Holds the word-recogniser state encoding and the ASCII characters it matches on.
package nbc_pkg;

    typedef enum logic [3:0] {
        S_GAP   = 4'd0,
        S_B1    = 4'd1,
        S_B2    = 4'd2,
        S_B3    = 4'd3,
        S_B4    = 4'd4,
        S_B5    = 4'd5,
        S_E1    = 4'd6,
        S_E2    = 4'd7,
        S_E3    = 4'd8,
        S_OTHER = 4'd9
    } state_t;

    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_TAB = 8'h09;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_B   = 8'h62;
    localparam logic [7:0] CH_E   = 8'h65;
    localparam logic [7:0] CH_G   = 8'h67;
    localparam logic [7:0] CH_I   = 8'h69;
    localparam logic [7:0] CH_N   = 8'h6E;
    localparam logic [7:0] CH_D   = 8'h64;

endpackage

// File: rtl/nbc_char_class.sv
// Character classifier: optional upper-to-lower folding and delimiter detection.
// Purely combinational so the recogniser sees the classified char in the same cycle.
module nbc_char_class
    import nbc_pkg::*;
#(
    parameter int CASE_FOLD = 1,
    parameter int DELIM_EXT = 1
) (
    input  logic [7:0] char_i,
    output logic [7:0] fold_o,
    output logic       delim_o
);

    logic isUpper;
    logic isExtDelim;

    assign isUpper    = (char_i >= 8'h41) && (char_i <= 8'h5A);
    assign fold_o     = ((CASE_FOLD != 0) && isUpper) ? (char_i | 8'h20) : char_i;
    assign isExtDelim = (char_i == CH_TAB) || (char_i == CH_LF) || (char_i == CH_CR);
    assign delim_o    = (char_i == CH_SP) || ((DELIM_EXT != 0) && isExtDelim);

endmodule

// File: rtl/nested_block_checker.sv
// Streaming begin/end nesting checker: recognises whole keywords between delimiters,
// keeps a committed depth with sticky under/overflow flags and a registered balance result.
module nested_block_checker
    import nbc_pkg::*;
#(
    parameter int DEPTH_W   = 8,
    parameter int CASE_FOLD = 1,
    parameter int DELIM_EXT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid,
    input  logic [7:0]         in,
    output logic               result,
    output logic [DEPTH_W-1:0] depth,
    output logic               err_under,
    output logic               err_over
);

    localparam logic [DEPTH_W-1:0] MAX_DEPTH = '1;
    localparam logic [DEPTH_W-1:0] ONE       = DEPTH_W'(1);

    logic [7:0]         chFold;
    logic               isDelim;

    state_t             state_q, state_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               under_q, under_d;
    logic               over_q,  over_d;
    logic               result_q, result_d;
    logic               tentOk;

    nbc_char_class #(
        .CASE_FOLD(CASE_FOLD),
        .DELIM_EXT(DELIM_EXT)
    ) u_class (
        .char_i (in),
        .fold_o (chFold),
        .delim_o(isDelim)
    );

    // A keyword only takes effect when the delimiter closing it arrives.
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        under_d = under_q;
        over_d  = over_q;
        if (isDelim) begin
            state_d = S_GAP;
            if (state_q == S_B5) begin
                if (depth_q == MAX_DEPTH) over_d = 1'b1;
                else                      depth_d = depth_q + ONE;
            end else if (state_q == S_E3) begin
                if (depth_q == '0) under_d = 1'b1;
                else               depth_d = depth_q - ONE;
            end
        end else begin
            case (state_q)
                S_GAP: begin
                    if (chFold == CH_B)      state_d = S_B1;
                    else if (chFold == CH_E) state_d = S_E1;
                    else                     state_d = S_OTHER;
                end
                S_B1:    state_d = (chFold == CH_E) ? S_B2 : S_OTHER;
                S_B2:    state_d = (chFold == CH_G) ? S_B3 : S_OTHER;
                S_B3:    state_d = (chFold == CH_I) ? S_B4 : S_OTHER;
                S_B4:    state_d = (chFold == CH_N) ? S_B5 : S_OTHER;
                S_E1:    state_d = (chFold == CH_N) ? S_E2 : S_OTHER;
                S_E2:    state_d = (chFold == CH_D) ? S_E3 : S_OTHER;
                default: state_d = S_OTHER;
            endcase
        end
    end

    // A pending "begin" can never leave the stream balanced; a pending "end" balances only from depth 1.
    always_comb begin
        tentOk = 1'b0;
        if (state_d == S_B5)      tentOk = 1'b0;
        else if (state_d == S_E3) tentOk = (depth_d == ONE);
        else                      tentOk = (depth_d == '0);
        result_d = !under_d && !over_d && tentOk;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_GAP;
            depth_q  <= '0;
            under_q  <= 1'b0;
            over_q   <= 1'b0;
            result_q <= 1'b1;
        end else if (valid) begin
            state_q  <= state_d;
            depth_q  <= depth_d;
            under_q  <= under_d;
            over_q   <= over_d;
            result_q <= result_d;
        end
    end

    assign result    = result_q;
    assign depth     = depth_q;
    assign err_under = under_q;
    assign err_over  = over_q;

endmodule

// File: tb/tb_nested_block_checker.sv
// Bench for nested_block_checker: table vectors, hand sequences for multi-cycle corners,
// and random keyword streams against a word-level reference model on three configurations.
module tb_nested_block_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] in = 8'h00;

    logic       resO[3];
    logic       euO[3];
    logic       eoO[3];
    logic [7:0] dep0, dep1;
    logic [1:0] dep2;

    int checks = 0;
    int errors = 0;

    // Instance 0: defaults; 1: no folding, space-only delimiters; 2: 2-bit depth counter.
    nested_block_checker #(.DEPTH_W(8), .CASE_FOLD(1), .DELIM_EXT(1)) dut (
        .clk(clk), .reset(reset), .valid(valid), .in(in),
        .result(resO[0]), .depth(dep0), .err_under(euO[0]), .err_over(eoO[0]));

    nested_block_checker #(.DEPTH_W(8), .CASE_FOLD(0), .DELIM_EXT(0)) dutNf (
        .clk(clk), .reset(reset), .valid(valid), .in(in),
        .result(resO[1]), .depth(dep1), .err_under(euO[1]), .err_over(eoO[1]));

    nested_block_checker #(.DEPTH_W(2), .CASE_FOLD(1), .DELIM_EXT(1)) dutW2 (
        .clk(clk), .reset(reset), .valid(valid), .in(in),
        .result(resO[2]), .depth(dep2), .err_under(euO[2]), .err_over(eoO[2]));

    always #5 clk = ~clk;

    // Word-level model: the current word is buffered and judged only against whole keywords.
    int   mMax[3]  = '{255, 255, 3};
    bit   mFold[3] = '{1'b1, 1'b0, 1'b1};
    bit   mExt[3]  = '{1'b1, 1'b0, 1'b1};
    int   mDepth[3];
    bit   mEu[3];
    bit   mEo[3];
    byte unsigned wBuf[3][6];
    int   wLen[3];

    function automatic bit wordIs(int k, string s);
        if (wLen[k] != s.len()) return 1'b0;
        for (int i = 0; i < s.len(); i++)
            if (wBuf[k][i] != s[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic modelStep(input bit r, input bit v, input logic [7:0] ch);
        byte unsigned c;
        bit           dl;
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                mDepth[k] = 0; mEu[k] = 1'b0; mEo[k] = 1'b0; wLen[k] = 0;
            end else if (v) begin
                c = ch;
                if (mFold[k] && c >= 8'h41 && c <= 8'h5A) c = c + 8'd32;
                dl = (c == 8'h20) || (mExt[k] && (c == 8'h09 || c == 8'h0A || c == 8'h0D));
                if (dl) begin
                    if (wordIs(k, "begin")) begin
                        if (mDepth[k] < mMax[k]) mDepth[k]++;
                        else                     mEo[k] = 1'b1;
                    end else if (wordIs(k, "end")) begin
                        if (mDepth[k] > 0) mDepth[k]--;
                        else               mEu[k] = 1'b1;
                    end
                    wLen[k] = 0;
                end else if (wLen[k] < 6) begin
                    wBuf[k][wLen[k]] = c;
                    wLen[k]++;
                end
            end
        end
    endtask

    function automatic bit modelResult(int k);
        if (mEu[k] || mEo[k])    return 1'b0;
        if (wordIs(k, "begin"))  return 1'b0;
        if (wordIs(k, "end"))    return mDepth[k] == 1;
        return mDepth[k] == 0;
    endfunction

    function automatic int depOf(int k);
        if (k == 0) return int'(dep0);
        if (k == 1) return int'(dep1);
        return int'(dep2);
    endfunction

    task automatic applyStimulus(input bit r, input bit v, input logic [7:0] ch);
        @(negedge clk);
        reset = r;
        valid = v;
        in    = ch;
        modelStep(r, v, ch);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic checkModel(input string tag);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("%s.u%0d.result", tag, k), int'(resO[k]), int'(modelResult(k)));
            checkOutput($sformatf("%s.u%0d.depth", tag, k), depOf(k), mDepth[k]);
            checkOutput($sformatf("%s.u%0d.err_under", tag, k), int'(euO[k]), int'(mEu[k]));
            checkOutput($sformatf("%s.u%0d.err_over", tag, k), int'(eoO[k]), int'(mEo[k]));
        end
    endtask

    task automatic sendStr(input string s);
        for (int i = 0; i < s.len(); i++) applyStimulus(1'b0, 1'b1, s[i]);
    endtask

    typedef struct {
        bit           r;
        bit           v;
        byte unsigned ch;
        bit           res;
        int           dep;
        bit           eu;
    } vec_t;

    vec_t tbl[$];

    // '!' = reset cycle, '~' = idle cycle with a space on the input; digits give expected outputs.
    task automatic addSeq(input string chars, input string res, input string dep, input string eu);
        vec_t v;
        for (int i = 0; i < chars.len(); i++) begin
            v.r   = (chars[i] == "!");
            v.v   = (chars[i] != "~");
            v.ch  = (chars[i] == "!" || chars[i] == "~") ? 8'h20 : chars[i];
            v.res = (res[i] == "1");
            v.dep = int'(dep[i]) - 48;
            v.eu  = (eu[i] == "1");
            tbl.push_back(v);
        end
    endtask

    string toks[7] = '{"begin", "end", "BeGiN", "END", "beginx", "en", "q"};
    byte unsigned dels[4] = '{8'h20, 8'h09, 8'h0A, 8'h0D};

    initial begin
        for (int k = 0; k < 3; k++) begin
            mDepth[k] = 0; mEu[k] = 1'b0; mEo[k] = 1'b0; wLen[k] = 0;
        end

        addSeq("!be~gin~ end ",   "1111110000011",   "0000000011110",   "0000000000000");
        addSeq("!end begin end ", "111000000000000", "000000000011110", "000011111111111");
        addSeq("!beginx endy ",   "1111101111011",   "0000000000000",   "0000000000000");

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].r, tbl[i].v, tbl[i].ch);
            checkOutput($sformatf("vec%0d.result", i), int'(resO[0]), int'(tbl[i].res));
            checkOutput($sformatf("vec%0d.depth", i), int'(dep0), tbl[i].dep);
            checkOutput($sformatf("vec%0d.err_under", i), int'(euO[0]), int'(tbl[i].eu));
            checkOutput($sformatf("vec%0d.err_over", i), int'(eoO[0]), 0);
        end

        // Mixed-case keyword: counted only by the folding instance.
        applyStimulus(1'b1, 1'b0, 8'h20);
        sendStr("BeGiN x");
        checkOutput("fold.depth", int'(dep0), 1);
        checkOutput("fold.result", int'(resO[0]), 0);
        checkOutput("nofold.depth", int'(dep1), 0);
        checkOutput("nofold.result", int'(resO[1]), 1);

        // Saturation of the 2-bit counter.
        applyStimulus(1'b1, 1'b1, 8'h62);
        sendStr("begin begin begin ");
        checkOutput("w2.depth3", int'(dep2), 3);
        checkOutput("w2.noover", int'(eoO[2]), 0);
        sendStr("begin");
        checkOutput("w2.pendmax.result", int'(resO[2]), 0);
        sendStr(" ");
        checkOutput("w2.sat.depth", int'(dep2), 3);
        checkOutput("w2.sat.err_over", int'(eoO[2]), 1);
        checkOutput("w2.sat.result", int'(resO[2]), 0);
        sendStr("end ");
        checkOutput("w2.after.depth", int'(dep2), 2);
        checkOutput("w2.after.result", int'(resO[2]), 0);
        checkOutput("w2.after.err_over", int'(eoO[2]), 1);

        // Idle cycles mid-word, then reset mid-word discards the partial keyword.
        applyStimulus(1'b1, 1'b0, 8'h20);
        sendStr("beg");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h20);
            checkOutput($sformatf("idle%0d.result", i), int'(resO[0]), 1);
            checkOutput($sformatf("idle%0d.depth", i), int'(dep0), 0);
        end
        sendStr("in ");
        checkOutput("gap.depth", int'(dep0), 1);
        checkOutput("gap.result", int'(resO[0]), 0);
        sendStr("beg");
        applyStimulus(1'b1, 1'b1, 8'h65);
        checkOutput("midrst.result", int'(resO[0]), 1);
        checkOutput("midrst.depth", int'(dep0), 0);
        sendStr("in ");
        checkOutput("postrst.depth", int'(dep0), 0);
        checkOutput("postrst.result", int'(resO[0]), 1);
        checkModel("hand");

        // Random keyword streams against the model.
        for (int t = 0; t < 300; t++) begin
            string tk;
            if ($urandom_range(99) < 4) begin
                applyStimulus(1'b1, 1'($urandom_range(1)), 8'($urandom_range(255)));
                checkModel($sformatf("rnd%0d.rst", t));
            end
            tk = toks[$urandom_range(6)];
            for (int i = 0; i <= tk.len(); i++) begin
                if ($urandom_range(9) == 0) begin
                    applyStimulus(1'b0, 1'b0, 8'($urandom_range(255)));
                    checkModel($sformatf("rnd%0d.idle", t));
                end
                if (i < tk.len()) applyStimulus(1'b0, 1'b1, tk[i]);
                else              applyStimulus(1'b0, 1'b1, dels[$urandom_range(3)]);
                checkModel($sformatf("rnd%0d.c%0d", t, i));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
